uart_rx: RTL

UART receiver, the counterpart of uart_tx on the loopback path. It samples the serial line rxd in the mclk domain and recovers 8-bit frames using the same runtime configuration as the transmitter: baud divisor, parity mode and stop-bit count. Each received byte is presented with a one-cycle valid strobe and per-frame error flags. The block sits between the board RX pin (or uart_tx.txd in loopback) and the byte consumer.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e : receiver/transmitter frame states
//   PAR_*        : parity_sel codes (2'b11 behaves as PAR_NONE)
//   STOP_*       : stop_sel codes
//   parity_on()  : true when a parity bit is present in the frame
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    function automatic logic parity_on(input logic [1:0] sel);
        return (sel == PAR_ODD) || (sel == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous single-bit input.
// Resets to 1 so an idle-high serial line does not produce a spurious edge.
//   clk_i : destination clock
//   rst_i : synchronous, active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (STAGES cycles of latency)
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1/8O2/etc. frames with runtime configuration.
//   mclk       : system clock
//   reset      : synchronous, active-high reset
//   baudrate   : mclk cycles per bit (4..65535)
//   parity_sel : 00/11 none, 01 odd, 10 even
//   stop_sel   : 0 one stop bit, 1 two stop bits
//   rxd        : asynchronous serial input, idle high
//   rdata      : last received byte, held until the next frame completes
//   valid      : one-cycle strobe when rdata and error flags update
//   parity_err : parity mismatch in the last frame
//   frame_err  : a stop-bit sample was 0 in the last frame
//   busy       : receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_BITS   = 8
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic [15:0]          baudrate,
    input  logic [1:0]           parity_sel,
    input  logic                 stop_sel,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

    logic rxd_s;
    logic rxd_d_q;

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [1:0] par_q, par_d;
    logic stop2_q, stop2_d;
    logic stop_idx_q, stop_idx_d;
    logic perr_q, perr_d;
    logic ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic pe_q, pe_d;
    logic fe_q, fe_d;
    logic valid_q, valid_d;

    logic [15:0] limit;
    logic tick;
    logic exp_par;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(mclk),
        .rst_i(reset),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    // START times out at half a bit so all later samples land mid-bit.
    assign limit   = (state_q == StStart) ? {1'b0, baud_q[15:1]} : baud_q;
    assign tick    = (cnt_q == limit - 16'd1);
    assign exp_par = (^shift_q) ^ (par_q == PAR_ODD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        baud_d     = baud_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        rdata_d    = rdata_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (rxd_d_q && !rxd_s) begin
                    state_d = StStart;
                    baud_d  = baudrate;
                    par_d   = parity_sel;
                    stop2_d = stop_sel;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rxd_s) begin
                        state_d = StIdle;  // false start
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == LastBit) begin
                        state_d    = parity_on(par_q) ? StParity : StStop;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    if (rxd_s != exp_par) begin
                        perr_d = 1'b1;
                    end
                    state_d    = StStop;
                    stop_idx_d = 1'b0;
                end
            end
            StStop: begin
                if (tick) begin
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
                    end
                    if ((stop2_q == STOP_TWO) && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                rdata_d = shift_q;
                pe_d    = perr_q;
                fe_d    = ferr_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            rxd_d_q    <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            baud_q     <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= STOP_ONE;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rdata_q    <= '0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            rxd_d_q    <= rxd_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            baud_q     <= baud_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rdata_q    <= rdata_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            valid_q    <= valid_d;
        end
    end

    assign rdata      = rdata_q;
    assign valid      = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != StIdle);

endmodule
